inst_cache_ctrl: RTL and testbench

// - Parametrised N-way set-associative instruction cache. Serves the fetch stage through an

---
 rtl/inst_cache_ctrl_pkg.sv | 43 ++++
 rtl/inst_cache_ctrl_if.sv | 42 ++++
 rtl/inst_cache_way.sv | 57 +++++
 rtl/inst_cache_ctrl.sv | 168 ++++++++++++++++
 tb/tb_inst_cache_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_cache_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_cache_ctrl_pkg                                           |
// | Purpose  : Default cache geometry, controller state encoding and helper  |
// |            functions that derive address field widths from geometry.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package inst_cache_ctrl_pkg;

   // Default geometry shared by the core configuration.
   localparam int RV_ICACHE_SETS   = 64;
   localparam int RV_ICACHE_WAYS   = 2;
   localparam int RV_ICACHE_BLOCKS = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      UPDATE = 2'd2,
      FLUSH  = 2'd3
   } ICacheState;

   // Byte offset within a block: bytes per word plus words per block.
   function automatic int offset_bits(input int inst_width, input int block_words);
      return $clog2(inst_width / 8) + $clog2(block_words);
   endfunction

   function automatic int index_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_bits(input int addr_width, input int inst_width,
                                   input int block_words, input int sets);
      return addr_width - offset_bits(inst_width, block_words) - index_bits(sets);
   endfunction

   // A one-way cache still needs a 1-bit pointer to keep vectors legal.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/inst_cache_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_cache_ctrl_if                                            |
// | Purpose  : Fetch-side and refill-side bus of the instruction cache.      |
// | Ports    : i_addr/i_re/i_flush  fetch request and flush pulse            |
// |            o_inst/o_busy        fetched block, not-ready indication      |
// |            o_mem_addr/o_mem_re  refill word request                      |
// |            i_mem_data/i_mem_valid refill data return                     |
// |            modport slave  = cache side, modport master = environment     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface inst_cache_ctrl_if
   import inst_cache_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int INST_WIDTH  = 32,
   parameter int BLOCK_WORDS = RV_ICACHE_BLOCKS
) ();

   logic [ADDR_WIDTH-1:0]             i_addr;
   logic                              i_re;
   logic [INST_WIDTH*BLOCK_WORDS-1:0] o_inst;
   logic                              o_busy;
   logic                              i_flush;
   logic [ADDR_WIDTH-1:0]             o_mem_addr;
   logic                              o_mem_re;
   logic [INST_WIDTH-1:0]             i_mem_data;
   logic                              i_mem_valid;

   modport slave (
      input  i_addr, i_re, i_flush, i_mem_data, i_mem_valid,
      output o_inst, o_busy, o_mem_addr, o_mem_re
   );

   // Fetch stage and instruction memory together form the master side.
   modport master (
      output i_addr, i_re, i_flush, i_mem_data, i_mem_valid,
      input  o_inst, o_busy, o_mem_addr, o_mem_re
   );

endinterface
`default_nettype wire

// File: rtl/inst_cache_way.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_cache_way                                                |
// | Purpose  : One way of the cache: per-set valid, tag and data flops.      |
// | Ports    : clk_i, rst_ni       clock, async active-low reset            |
// |            lk_index_i/lk_tag_i lookup address fields -> hit_o, block_o   |
// |            we_i/wr_*           install a block at wr_index_i             |
// |            clr_i/clr_index_i   invalidate one set                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module inst_cache_way #(
   parameter int SETS  = 64,
   parameter int TAG_W = 22,
   parameter int IDX_W = 6,
   parameter int BLK_W = 128
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX_W-1:0] lk_index_i,
   input  logic [TAG_W-1:0] lk_tag_i,
   output logic             hit_o,
   output logic [BLK_W-1:0] block_o,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_index_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  logic [BLK_W-1:0] wr_block_i,
   input  logic             clr_i,
   input  logic [IDX_W-1:0] clr_index_i
);

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [BLK_W-1:0] data_q [SETS];

   assign hit_o   = valid_q[lk_index_i] && (tag_q[lk_index_i] == lk_tag_i);
   assign block_o = data_q[lk_index_i];

   // Only valid bits need reset; tag/data are qualified by valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (clr_i) begin
         valid_q[clr_index_i] <= 1'b0;
      end else if (we_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_block_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/inst_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_cache_ctrl                                               |
// | Purpose  : N-way set-associative instruction cache with 0-cycle hits,    |
// |            word-by-word block refill, round-robin replacement and a      |
// |            one-set-per-cycle flush.                                      |
// | Ports    : i_clock  rising-edge clock                                    |
// |            i_reset  asynchronous active-low reset                        |
// |            bus      inst_cache_ctrl_if.slave (fetch + refill signals)    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module inst_cache_ctrl
   import inst_cache_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int INST_WIDTH  = 32,
   parameter int BLOCK_WORDS = RV_ICACHE_BLOCKS,
   parameter int SETS        = RV_ICACHE_SETS,
   parameter int WAYS        = RV_ICACHE_WAYS
) (
   input  logic             i_clock,
   input  logic             i_reset,
   inst_cache_ctrl_if.slave bus
);

   localparam int WORD_BYTES = INST_WIDTH / 8;
   localparam int OFF_W      = offset_bits(INST_WIDTH, BLOCK_WORDS);
   localparam int IDX_W      = index_bits(SETS);
   localparam int TAG_W      = tag_bits(ADDR_WIDTH, INST_WIDTH, BLOCK_WORDS, SETS);
   localparam int BLK_W      = INST_WIDTH * BLOCK_WORDS;
   localparam int WCNT_W     = $clog2(BLOCK_WORDS) + 1;
   localparam int WAY_W      = way_bits(WAYS);
   localparam int BASE_W     = ADDR_WIDTH - OFF_W;

   ICacheState                  state_q;
   logic [BASE_W-1:0]           base_q;     // block address of the refill, offset dropped
   logic [WAY_W-1:0]            victim_q;
   logic [WCNT_W-1:0]           wcnt_q;
   logic [IDX_W-1:0]            fcnt_q;
   logic                        flush_pend_q;
   logic                        mem_re_q;
   logic [ADDR_WIDTH-1:0]       mem_addr_q;
   logic [BLK_W-1:0]            line_q;
   logic [SETS-1:0][WAY_W-1:0]  rr_q;

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_base_idx;
   logic [TAG_W-1:0] w_base_tag;
   logic [WAYS-1:0]  w_way_hit;
   logic [BLK_W-1:0] w_way_block [WAYS];
   logic             w_hit;
   logic [BLK_W-1:0] w_block;
   logic             w_miss;

   assign w_idx      = bus.i_addr[OFF_W +: IDX_W];
   assign w_tag      = bus.i_addr[ADDR_WIDTH-1 -: TAG_W];
   assign w_base_idx = base_q[IDX_W-1:0];
   assign w_base_tag = base_q[BASE_W-1 -: TAG_W];

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      inst_cache_way #(
         .SETS  (SETS),
         .TAG_W (TAG_W),
         .IDX_W (IDX_W),
         .BLK_W (BLK_W)
      ) u_way (
         .clk_i       (i_clock),
         .rst_ni      (i_reset),
         .lk_index_i  (w_idx),
         .lk_tag_i    (w_tag),
         .hit_o       (w_way_hit[g]),
         .block_o     (w_way_block[g]),
         .we_i        ((state_q == UPDATE) && (victim_q == WAY_W'(g))),
         .wr_index_i  (w_base_idx),
         .wr_tag_i    (w_base_tag),
         .wr_block_i  (line_q),
         .clr_i       (state_q == FLUSH),
         .clr_index_i (fcnt_q)
      );
   end

   // At most one way can hold a given tag, so a priority-free OR-style mux suffices.
   always_comb begin
      w_hit   = 1'b0;
      w_block = '0;
      for (int k = 0; k < WAYS; k++) begin
         if (w_way_hit[k]) begin
            w_hit   = 1'b1;
            w_block = w_way_block[k];
         end
      end
   end

   assign w_miss = bus.i_re & ~w_hit;

   // Busy and data are gated by reset so both read zero while reset is held.
   assign bus.o_busy     = i_reset & ((state_q != IDLE) | w_miss);
   assign bus.o_inst     = (i_reset && (state_q == IDLE) && w_hit) ? w_block : '0;
   assign bus.o_mem_re   = mem_re_q;
   assign bus.o_mem_addr = mem_addr_q;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= IDLE;
         base_q       <= '0;
         victim_q     <= '0;
         wcnt_q       <= '0;
         fcnt_q       <= '0;
         flush_pend_q <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_addr_q   <= '0;
         line_q       <= '0;
         rr_q         <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // Flush has priority; a simultaneous miss is simply re-seen afterwards.
               if (bus.i_flush) begin
                  state_q <= FLUSH;
                  fcnt_q  <= '0;
               end else if (w_miss) begin
                  state_q    <= REFILL;
                  base_q     <= bus.i_addr[ADDR_WIDTH-1:OFF_W];
                  victim_q   <= rr_q[w_idx];
                  wcnt_q     <= '0;
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= {bus.i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
               end
            end
            REFILL: begin
               if (bus.i_flush) begin
                  flush_pend_q <= 1'b1;
               end
               if (bus.i_mem_valid) begin
                  for (int k = 0; k < BLOCK_WORDS; k++) begin
                     if (wcnt_q == WCNT_W'(k)) begin
                        line_q[k*INST_WIDTH +: INST_WIDTH] <= bus.i_mem_data;
                     end
                  end
                  wcnt_q     <= wcnt_q + WCNT_W'(1);
                  mem_addr_q <= mem_addr_q + ADDR_WIDTH'(WORD_BYTES);
                  if (wcnt_q == WCNT_W'(BLOCK_WORDS - 1)) begin
                     mem_re_q <= 1'b0;
                     state_q  <= UPDATE;
                  end
               end
            end
            UPDATE: begin
               rr_q[w_base_idx] <= (WAYS == 1) ? '0 : victim_q + WAY_W'(1);
               flush_pend_q     <= 1'b0;
               fcnt_q           <= '0;
               // A flush seen during the refill also wipes the line just installed.
               state_q          <= (flush_pend_q || bus.i_flush) ? FLUSH : IDLE;
            end
            FLUSH: begin
               fcnt_q <= fcnt_q + IDX_W'(1);
               if (fcnt_q == IDX_W'(SETS - 1)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_inst_cache_ctrl                                            |
// | Purpose  : Scoreboard bench for inst_cache_ctrl: directed fetches push   |
// |            expected block / busy cycles / refill cycles; a monitor pops  |
// |            and compares whenever the cache answers a fetch.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_inst_cache_ctrl;

   localparam int AW    = 32;
   localparam int IW    = 32;
   localparam int BW    = 4;
   localparam int SETS  = 64;
   localparam int WAYS  = 2;
   localparam int BLK_W = IW * BW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inst_cache_ctrl_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .BLOCK_WORDS(BW)) bus ();

   inst_cache_ctrl #(
      .ADDR_WIDTH  (AW),
      .INST_WIDTH  (IW),
      .BLOCK_WORDS (BW),
      .SETS        (SETS),
      .WAYS        (WAYS)
   ) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [AW-1:0]    addr;
      logic [BLK_W-1:0] inst;
      int               lat;
      int               re;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   passed    = 0;
   int   n_resp    = 0;
   int   busy_cnt  = 0;
   int   re_cnt    = 0;
   bit   stall_en  = 1'b0;
   int   stall_cnt = 0;

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return 32'hA500_0000 | a;
   endfunction

   function automatic logic [BLK_W-1:0] blk(input logic [AW-1:0] base);
      return {mem_word(base + 32'd12), mem_word(base + 32'd8),
              mem_word(base + 32'd4), mem_word(base)};
   endfunction

   task automatic check_blk(input string name, input logic [BLK_W-1:0] act,
                            input logic [BLK_W-1:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Instruction memory: 2-cycle latency per word, 12 for 0x304 when stalling.
   initial begin : mem_model
      int age;
      int lat;
      age = 0;
      bus.i_mem_valid = 1'b0;
      bus.i_mem_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         lat = (stall_en && bus.o_mem_addr == 32'h304) ? 12 : 2;
         if (!rst_n || !bus.o_mem_re) begin
            bus.i_mem_valid = 1'b0;
            age = 0;
         end else if (age == lat - 1) begin
            bus.i_mem_valid = 1'b1;
            bus.i_mem_data  = mem_word(bus.o_mem_addr);
            age = 0;
         end else begin
            bus.i_mem_valid = 1'b0;
            age++;
         end
         if (rst_n && bus.o_mem_re && bus.o_mem_addr == 32'h304) stall_cnt++;
      end
   end

   // Monitor: a fetch completes when i_re is high and o_busy is low.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt = 0;
            re_cnt   = 0;
         end else if (bus.i_re) begin
            if (bus.o_mem_re) re_cnt++;
            if (bus.o_busy) begin
               busy_cnt++;
            end else if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_resp: response for %h, expected none", bus.i_addr);
               n_resp++;
            end else begin
               e = exp_q.pop_front();
               check_blk($sformatf("inst@%h", e.addr), bus.o_inst, e.inst);
               check_int($sformatf("busy_cycles@%h", e.addr), busy_cnt, e.lat);
               check_int($sformatf("mem_re_cycles@%h", e.addr), re_cnt, e.re);
               busy_cnt = 0;
               re_cnt   = 0;
               n_resp++;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the response.
   task automatic fetch(input logic [AW-1:0] a, input logic [BLK_W-1:0] inst,
                        input int lat, input int re);
      exp_t e;
      int   start;
      e.addr = a;
      e.inst = inst;
      e.lat  = lat;
      e.re   = re;
      exp_q.push_back(e);
      start      = n_resp;
      bus.i_addr = a;
      bus.i_re   = 1'b1;
      for (int i = 0; i < 400 && n_resp == start; i++) @(negedge clk);
      if (n_resp == start) begin
         checks++;
         $display("FAIL fetch_timeout@%h: no response, expected one", a);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      bus.i_re = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      bus.i_addr  = 32'h100;
      bus.i_re    = 1'b1;
      bus.i_flush = 1'b0;

      // Reset: outputs quiet even with a read request pending.
      #3;
      check_int("rst_busy", int'(bus.o_busy), 0);
      check_int("rst_mem_re", int'(bus.o_mem_re), 0);
      check_int("rst_mem_addr", int'(bus.o_mem_addr), 0);
      check_blk("rst_inst", bus.o_inst, '0);
      @(posedge clk); #1;
      bus.i_re = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Cold miss then hits in the same block.
      fetch(32'h100, 128'hA500010C_A5000108_A5000104_A5000100, 10, 8);
      fetch(32'h108, blk(32'h100), 0, 0);
      fetch(32'h10C, blk(32'h100), 0, 0);

      // Set-0 conflicts and round-robin eviction.
      fetch(32'h0000, blk(32'h0000), 10, 8);
      fetch(32'h0400, blk(32'h0400), 10, 8);
      fetch(32'h0800, blk(32'h0800), 10, 8);
      fetch(32'h0400, blk(32'h0400), 0, 0);
      fetch(32'h0000, blk(32'h0000), 10, 8);
      fetch(32'h0800, blk(32'h0800), 0, 0);

      // Flush from IDLE: one busy cycle per set, then a previously cached line misses.
      bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.o_busy) n++;
         else if (n > 0) break;
      end
      check_int("flush_busy_cycles", n, SETS);
      @(posedge clk); #1;
      fetch(32'h100, blk(32'h100), 10, 8);

      // Flush during refill: refill, update, full flush, then the line refills again.
      fork
         fetch(32'h200, blk(32'h200), 84, 16);
         begin
            repeat (3) @(posedge clk);
            #1 bus.i_flush = 1'b1;
            @(posedge clk);
            #1 bus.i_flush = 1'b0;
         end
      join

      // 10-cycle stall on word 1: request held; penalty = 2+12+2+2 + 2.
      stall_en  = 1'b1;
      stall_cnt = 0;
      fetch(32'h300, blk(32'h300), 20, 18);
      stall_en  = 1'b0;
      check_int("stall_addr_hold_cycles", stall_cnt, 12);

      // Re-install 0x100 (flushed above) so the reset test can show it is lost.
      fetch(32'h100, blk(32'h100), 10, 8);

      // Asynchronous reset in the middle of refill word 2 of 0x500.
      bus.i_addr = 32'h500;
      bus.i_re   = 1'b1;
      n = 0;
      while (n < 50 && bus.o_mem_addr != 32'h508) begin
         @(negedge clk);
         n++;
      end
      check_int("rst_reach_word2", int'(bus.o_mem_addr == 32'h508), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_int("async_rst_mem_re", int'(bus.o_mem_re), 0);
      check_int("async_rst_busy", int'(bus.o_busy), 0);
      check_int("async_rst_mem_addr", int'(bus.o_mem_addr), 0);
      @(posedge clk); #1;
      bus.i_re = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      fetch(32'h100, blk(32'h100), 10, 8);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
